msk_mux_n_pipe: RTL and testbench
=================================

MSK_MUX_N_PIPE -- requirements
Module: msk_mux_n_pipe

Interface
REQ-001 Parameter d, default 2, number of shares per masked bit.
REQ-002 Parameter count, default 1, number of masked bits per way.
REQ-003 Parameter ways, default 4, number of selectable input sharings, legal range 2..16.
REQ-004 Derived constant SELW = max(1, ceil(log2(ways))), width of sel.
REQ-005 clk  input  1  single clock, all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  upstream presents sel and in_data.
REQ-008 in_ready  output  1  block accepts the beat this cycle.
REQ-009 sel  input  SELW  non-sensitive control, way index.
REQ-010 in_data  input  ways*count*d  sharings; way w occupies bits [(w+1)*count*d-1 : w*count*d].
REQ-011 out_valid  output  1  out_data holds a selected sharing.
REQ-012 out_ready  input  1  downstream accepts out_data.
REQ-013 out_data  output  count*d  selected sharing, same share layout as one way.
REQ-014 err  output  1  sticky out-of-range flag, present only with MSK_MUX_SEL_CHECK_EN.

Function
REQ-015 Transfer in occurs when in_valid & in_ready. Transfer out occurs when out_valid & out_ready.
REQ-016 On a transfer in, the block captures way sel of in_data into a 2-entry FIFO.
REQ-017 Latency is 1 cycle: data accepted in cycle N is on out_data with out_valid=1 in cycle N+1 when the FIFO was empty.
REQ-018 in_ready is a register output: it is 1 iff occupancy < 2 after the current edge. It never depends combinationally on in_valid or out_ready.
REQ-019 out_valid = (occupancy != 0). out_data is the oldest entry, driven directly from a register.
REQ-020 Occupancy transitions:
  - transfer in only: +1.
  - transfer out only: -1.
  - both transfers together: unchanged, FIFO order preserved.
  - full (2) with out_ready=0: in_ready=0 and the stored entries are held unchanged.
REQ-021 While out_valid=1 and out_ready=0, out_data is stable.
REQ-022 The sel value is used only as a mux control. Share j of every output bit derives only from share j of the chosen way. No logic combines different shares or different ways' shares beyond the one-hot share-wise selection.
REQ-023 Storage registers load only on a transfer in, so no intermediate share values are glitched into state.
REQ-024 If sel >= ways, the captured sharing is all-zero.

Reset
REQ-025 When rst=1 at an edge: occupancy=0, out_valid=0, in_ready=1, out_data=0, err=0.
REQ-026 Reset mid-operation discards all buffered entries. Any transfer in during the reset cycle is ignored.

Configuration
REQ-027 With MSK_MUX_SEL_CHECK_EN defined, err is set at the first transfer in with sel >= ways and stays set until rst.
REQ-028 Without MSK_MUX_SEL_CHECK_EN, the err port and its logic are absent. Out-of-range behaviour is REQ-024 only.

Structure
REQ-029 Package msk_pkg holds the SELW computation function and the DEFAULTSHARES constant (2).
REQ-030 One sub-module, msk_mux_n_sel (combinational, share-wise ways-to-1 selection), is instantiated once. The FIFO stays in the top module.

Verification
REQ-031 Basic: d=2, count=1, ways=4, sel=2, in_data=8'b10_01_11_00, out_ready=1 -> next cycle out_valid=1, out_data=2'b01.
REQ-032 Backpressure: out_ready=0, push 3 beats with sel=0,1,3 -> first two accepted, in_ready=0 after the second, third held. Releasing out_ready -> outputs appear in order 0,1,3 with no loss.
REQ-033 Simultaneous: occupancy=1, in_valid=1 and out_ready=1 each cycle for 10 cycles -> occupancy stays 1, one beat out per cycle, order preserved.
REQ-034 Reset mid-stream: occupancy=2, rst pulsed 1 cycle with in_valid=1 -> out_valid=0, in_ready=1, nothing emitted from the prior beats.
REQ-035 Range check: ways=3, sel=3 with MSK_MUX_SEL_CHECK_EN -> out_data=0 and err=1 from the next cycle until rst. Without the macro -> out_data=0 and no err port.
REQ-036 Share isolation: d=3, count=2, random sharings with share 1 forced to 0 on all ways -> share 1 of out_data is always 0.

Source files
------------

// File: rtl/msk_pkg.sv
// Shared constants and helpers for the masked share-wise multiplexer.
package msk_pkg;

    localparam int DEFAULTSHARES = 2;

    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/msk_mux_n_sel.sv
// Share-wise ways-to-1 selection; each output share comes only from the same share of one way.
module msk_mux_n_sel
    import msk_pkg::*;
#(
    parameter int d     = DEFAULTSHARES,
    parameter int count = 1,
    parameter int ways  = 4
) (
    input  logic [sel_width(ways)-1:0]  sel,
    input  logic [ways*count*d-1:0]     in_data,
    output logic [count*d-1:0]          out_data
);

    localparam int CD   = count * d;
    localparam int SELW = sel_width(ways);

    // An out-of-range sel matches no way, so the result is all-zero.
    always_comb begin
        out_data = '0;
        for (int w = 0; w < ways; w++) begin
            out_data = out_data
                     | (in_data[w*CD +: CD] & {CD{sel == SELW'(w)}});
        end
    end

endmodule

// File: rtl/msk_mux_n_pipe.sv
// Masked share-wise mux with a 2-entry output FIFO.
// Define MSK_MUX_SEL_CHECK_EN to add the sticky err output for sel >= ways.
module msk_mux_n_pipe
    import msk_pkg::*;
#(
    parameter int d     = DEFAULTSHARES,
    parameter int count = 1,
    parameter int ways  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [sel_width(ways)-1:0]  sel,
    input  logic [ways*count*d-1:0]     in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [count*d-1:0]          out_data
`ifdef MSK_MUX_SEL_CHECK_EN
    ,
    output logic                        err
`endif
);

    localparam int CD = count * d;

    logic [CD-1:0] pick;
    logic [CD-1:0] head;
    logic [CD-1:0] tail;
    logic [1:0]    occ;
    logic          push;
    logic          pop;

    msk_mux_n_sel #(
        .d     (d),
        .count (count),
        .ways  (ways)
    ) u_sel (
        .sel      (sel),
        .in_data  (in_data),
        .out_data (pick)
    );

    assign push     = in_valid & in_ready;
    assign pop      = out_valid & out_ready;
    assign out_data = head;

    // head is always the oldest entry; tail only ever holds a second one.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ       <= 2'd0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            head      <= '0;
            tail      <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) head <= pick;
                    else             tail <= pick;
                    occ       <= occ + 2'd1;
                    in_ready  <= (occ == 2'd0);
                    out_valid <= 1'b1;
                end
                2'b01: begin
                    if (occ == 2'd2) head <= tail;
                    occ       <= occ - 2'd1;
                    in_ready  <= 1'b1;
                    out_valid <= (occ == 2'd2);
                end
                2'b11: begin
                    head <= pick;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef MSK_MUX_SEL_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst)                            err <= 1'b0;
        else if (push && int'(sel) >= ways) err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_msk_mux_n_pipe.sv
// Bench for msk_mux_n_pipe: queue model on a 4-way instance, directed checks on a 3-way one.
module tb_msk_mux_n_pipe;

    logic       clk = 1'b0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    // Instance A: d=2, count=1, ways=4
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] sel = '0;
    logic [7:0] in_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [1:0] out_data;
`ifdef MSK_MUX_SEL_CHECK_EN
    logic       err;
`endif

    msk_mux_n_pipe #(.d(2), .count(1), .ways(4)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef MSK_MUX_SEL_CHECK_EN
        ,
        .err       (err)
`endif
    );

    // Instance B: d=3, count=2, ways=3
    logic        b_rst = 1'b1;
    logic        b_in_valid = 1'b0;
    logic        b_in_ready;
    logic [1:0]  b_sel = '0;
    logic [17:0] b_in_data = '0;
    logic        b_out_valid;
    logic        b_out_ready = 1'b0;
    logic [5:0]  b_out_data;
`ifdef MSK_MUX_SEL_CHECK_EN
    logic        b_err;
`endif

    msk_mux_n_pipe #(.d(3), .count(2), .ways(3)) dut_b (
        .clk       (clk),
        .rst       (b_rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .sel       (b_sel),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data)
`ifdef MSK_MUX_SEL_CHECK_EN
        ,
        .err       (b_err)
`endif
    );

    // Reference model for A: a FIFO of captured sharings, capacity 2.
    logic [1:0] q[$];
    bit         started = 0;
    bit         after_rst = 0;
    bit         m_push;
    bit         m_pop;
    logic [1:0] m_val;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            started   = 1;
            after_rst = 1;
        end else begin
            m_push = in_valid && (q.size() < 2);
            m_pop  = (q.size() != 0) && out_ready;
            m_val  = (int'(sel) < 4) ? in_data[int'(sel)*2 +: 2] : 2'b00;
            if (m_pop)  void'(q.pop_front());
            if (m_push) q.push_back(m_val);
            if (m_push) after_rst = 0;
        end
        #1;
        if (started) begin
            chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
            chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
            if (q.size() != 0)
                chk("out_data", {30'd0, out_data}, {30'd0, q[0]});
            else if (after_rst)
                chk("out_data_rst", {30'd0, out_data}, 32'd0);
        end
    end

    logic [17:0] prev_data;
    int          prev_sel;
    logic [5:0]  exp_b;

    initial begin
        // reset both instances
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {30'd0, out_data}, 32'd0);
        chk("b_rst_out_valid", {31'd0, b_out_valid}, 32'd0);
`ifdef MSK_MUX_SEL_CHECK_EN
        chk("b_rst_err", {31'd0, b_err}, 32'd0);
`endif
        rst   = 1'b0;
        b_rst = 1'b0;

        // basic selection
        @(negedge clk);
        in_valid  = 1'b1;
        sel       = 2'd2;
        in_data   = 8'b10_01_11_00;
        out_ready = 1'b1;
        @(negedge clk);
        chk("basic_valid", {31'd0, out_valid}, 32'd1);
        chk("basic_data", {30'd0, out_data}, 32'd1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("basic_drain", {31'd0, out_valid}, 32'd0);

        // backpressure: sel 0,1,3 with out_ready low
        out_ready = 1'b0;
        in_data   = 8'b11_10_01_00;
        in_valid  = 1'b1;
        sel       = 2'd0;
        @(negedge clk);
        chk("bp_first", {30'd0, out_data}, 32'd0);
        sel = 2'd1;
        @(negedge clk);
        chk("bp_full", {31'd0, in_ready}, 32'd0);
        sel = 2'd3;
        @(negedge clk);
        @(negedge clk);
        chk("bp_hold_rdy", {31'd0, in_ready}, 32'd0);
        chk("bp_hold_data", {30'd0, out_data}, 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_second", {30'd0, out_data}, 32'd1);
        @(negedge clk);
        chk("bp_third", {30'd0, out_data}, 32'd3);
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_empty", {31'd0, out_valid}, 32'd0);

        // simultaneous push/pop at occupancy 1
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'b00_11_01_10;
        sel       = 2'd0;
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sel = 2'(i + 1);
            @(negedge clk);
            chk("sim_occ1", {30'd0, q.size() == 1, out_valid}, 32'd3);
        end
        in_valid = 1'b0;
        repeat (2) @(negedge clk);

        // reset with two entries buffered and a beat offered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sel       = 2'd3;
        repeat (2) @(negedge clk);
        chk("pre_rst_full", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        repeat (3) @(negedge clk);
        chk("post_rst_quiet", {31'd0, out_valid}, 32'd0);

        // random traffic, all sel in range
        for (int i = 0; i < 200; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            sel       = 2'($urandom_range(0, 3));
            in_data   = 8'($urandom);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);

        // out-of-range sel on the 3-way instance
        b_in_valid  = 1'b1;
        b_sel       = 2'd3;
        b_in_data   = '1;
        b_out_ready = 1'b1;
        @(negedge clk);
        chk("range_valid", {31'd0, b_out_valid}, 32'd1);
        chk("range_zero", {26'd0, b_out_data}, 32'd0);
`ifdef MSK_MUX_SEL_CHECK_EN
        chk("range_err", {31'd0, b_err}, 32'd1);
`endif
        b_in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("range_drained", {31'd0, b_out_valid}, 32'd0);
`ifdef MSK_MUX_SEL_CHECK_EN
        chk("range_err_sticky", {31'd0, b_err}, 32'd1);
`endif
        b_rst = 1'b1;
        @(negedge clk);
        b_rst = 1'b0;
        chk("b_rst_ready", {31'd0, b_in_ready}, 32'd1);
`ifdef MSK_MUX_SEL_CHECK_EN
        chk("range_err_clr", {31'd0, b_err}, 32'd0);
`endif

        // share isolation: share 1 zero on every way
        b_in_valid  = 1'b1;
        b_out_ready = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            if (k > 0) begin
                exp_b = prev_data[prev_sel*6 +: 6];
                chk("iso_valid", {31'd0, b_out_valid}, 32'd1);
                chk("iso_share1", {30'd0, b_out_data[4], b_out_data[1]}, 32'd0);
                chk("iso_data", {26'd0, b_out_data}, {26'd0, exp_b});
            end
            if (k < 20) begin
                prev_sel  = int'($urandom_range(0, 2));
                prev_data = 18'($urandom) & {3{6'b101101}};
                b_sel     = 2'(prev_sel);
                b_in_data = prev_data;
                @(negedge clk);
            end
        end
        b_in_valid = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
